// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// State encoding and transfer-direction values.
package sram_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ISSUE  = 2'd1;
  localparam state_t RDWAIT = 2'd2;
  localparam state_t RESP   = 2'd3;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  function automatic logic [1:0] onehot2(logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Client-side bundle of the SRAM port arbiter.
// The arbiter takes the slave view, the requesters the master view.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_rw;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                busy;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

endinterface

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin arbiter.
// With both requesting, the side that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [0:0] last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = last[0] ? 2'b01 : 2'b10;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one registered-output single-port SRAM between two requesters,
// one transaction at a time, with round-robin fairness.
module sram_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_port_arbiter_if.slave cl,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t r_state;
  state_t w_next;

  logic              r_owner;
  logic              r_last;
  logic              r_mem_rw;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [1:0]        r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_owner;
  logic              w_last;
  logic              w_mem_rw;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [1:0]        w_rsp_valid;
  logic [DATA_W-1:0] w_rsp_rdata;

  logic [1:0] w_gnt;
  logic       w_sel;
  logic       w_acc;

  rr_arb2 u_arb (
    .req  (cl.req_valid),
    .last (r_last),
    .gnt  (w_gnt)
  );

  assign w_sel        = w_gnt[1];
  assign cl.req_ready = (r_state == IDLE) ? w_gnt : 2'b00;
  assign w_acc        = |(cl.req_valid & cl.req_ready);
  assign cl.busy      = (r_state != IDLE);

  assign cl.rsp_valid = r_rsp_valid;
  assign cl.rsp_rdata = r_rsp_rdata;
  assign mem_rw       = r_mem_rw;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_acc) w_next = ISSUE;
      ISSUE:   w_next = (r_mem_rw == WR) ? RESP : RDWAIT;
      RDWAIT:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // mem_rw defaults low so it is only high during ISSUE of a write
  always_comb begin
    w_owner     = r_owner;
    w_last      = r_last;
    w_mem_rw    = RD;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_rsp_valid = 2'b00;
    w_rsp_rdata = r_rsp_rdata;
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_owner     = w_sel;
          w_last      = w_sel;
          w_mem_rw    = cl.req_rw[w_sel];
          w_mem_addr  = w_sel ? cl.req_addr[2*ADDR_W-1:ADDR_W]
                              : cl.req_addr[ADDR_W-1:0];
          w_mem_wdata = w_sel ? cl.req_wdata[2*DATA_W-1:DATA_W]
                              : cl.req_wdata[DATA_W-1:0];
        end
      end
      ISSUE: begin
        if (r_mem_rw == WR) w_rsp_valid = onehot2(r_owner);
      end
      RDWAIT: begin
        w_rsp_rdata = mem_rdata;
        w_rsp_valid = onehot2(r_owner);
      end
      RESP: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_mem_rw    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= '0;
    end else begin
      r_owner     <= w_owner;
      r_last      <= w_last;
      r_mem_rw    <= w_mem_rw;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM
// and a response scoreboard fed at every accepted request.
module tb_sram_port_arbiter;

  logic clk;
  logic rst_n;
  logic       mem_rw;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       sram_rst;

  int total;
  int bad;
  int cyc;

  typedef struct {
    bit         owner;
    bit         rd;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       q[$];
  logic [7:0] ref_mem[16];
  logic [7:0] sram[16];

  sram_port_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  sram_port_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cl        (bus),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: registered data_out, active-high reset clears only data_out
  assign sram_rst = ~rst_n;
  always @(posedge clk or posedge sram_rst) begin
    if (sram_rst) begin
      mem_rdata <= 8'h00;
    end else begin
      if (mem_rw) sram[mem_addr] <= mem_wdata;
      mem_rdata <= sram[mem_addr];
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push at accept, pop/compare when a response appears
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      chk("ready_onehot", 32'(bus.req_ready != 2'b11), 32'd1);
      chk("mem_rw_idle", 32'(mem_rw & ~bus.busy), 32'd0);
      if (bus.rsp_valid != 2'b00) begin
        if (q.size() == 0) begin
          chk("unexp_rsp", 32'(bus.rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_owner", 32'(bus.rsp_valid),
              e.owner ? 32'd2 : 32'd1);
          chk("rsp_cycle", cyc, e.due);
          if (e.rd) chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.data));
        end
      end else if (q.size() > 0 && cyc > q[0].due) begin
        chk("rsp_missing", cyc, q[0].due);
        void'(q.pop_front());
      end
      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          exp_t e;
          logic [3:0] a;
          a       = bus.req_addr[i*4 +: 4];
          e.owner = (i == 1);
          e.rd    = !bus.req_rw[i];
          e.data  = e.rd ? ref_mem[a] : 8'h00;
          e.due   = cyc + (e.rd ? 3 : 2);
          q.push_back(e);
          if (!e.rd) ref_mem[a] = bus.req_wdata[i*8 +: 8];
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n1;
    int last_acc;
    bit exp_g;
    int cnt;
    logic [1:0] g;

    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_rw = 2'b00;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    step();
    step();

    // reset state
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // 1: req0 write addr 3 = A5
    bus.req_valid = 2'b01;
    bus.req_rw = 2'b01;
    bus.req_addr[3:0] = 4'd3;
    bus.req_wdata[7:0] = 8'hA5;
    @(negedge clk);
    chk("t1_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("t1_mem_rw", 32'(mem_rw), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'd3);
    chk("t1_mem_wdata", 32'(mem_wdata), 32'hA5);
    step();
    @(negedge clk);
    chk("t1_mem_rw_low", 32'(mem_rw), 32'd0);
    chk("t1_rsp", 32'(bus.rsp_valid), 32'd1);
    step();

    // 2: req1 read addr 3
    bus.req_valid = 2'b10;
    bus.req_rw = 2'b00;
    bus.req_addr[7:4] = 4'd3;
    @(negedge clk);
    chk("t2_ready", 32'(bus.req_ready), 32'd2);
    chk("t2_busy_t0", 32'(bus.busy), 32'd0);
    step();
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("t2_busy_t1", 32'(bus.busy), 32'd1);
    step();
    @(negedge clk);
    chk("t2_busy_t2", 32'(bus.busy), 32'd1);
    chk("t2_no_rsp_t2", 32'(bus.rsp_valid), 32'd0);
    step();
    @(negedge clk);
    chk("t2_busy_t3", 32'(bus.busy), 32'd1);
    chk("t2_rsp", 32'(bus.rsp_valid), 32'd2);
    chk("t2_rdata", 32'(bus.rsp_rdata), 32'hA5);
    step();
    @(negedge clk);
    chk("t2_busy_t4", 32'(bus.busy), 32'd0);
    step();

    // 3: both valid continuously, 4 writes each
    n0 = 0;
    n1 = 0;
    last_acc = -1;
    exp_g = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_rw = 2'b11;
    bus.req_addr = {4'd8, 4'd4};
    bus.req_wdata = {8'h20, 8'h10};
    for (int c = 0; c < 60 && (n0 < 4 || n1 < 4); c++) begin
      @(negedge clk);
      g = bus.req_ready & bus.req_valid;
      if (g != 2'b00) begin
        chk("t3_grant", 32'(g), exp_g ? 32'd2 : 32'd1);
        if (last_acc >= 0) chk("t3_gap", cyc - last_acc, 32'd3);
        last_acc = cyc;
        exp_g = ~exp_g;
      end
      step();
      if (g[0]) begin
        n0++;
        if (n0 < 4) begin
          bus.req_addr[3:0] = 4'(4 + n0);
          bus.req_wdata[7:0] = 8'(8'h10 + n0);
        end else bus.req_valid[0] = 1'b0;
      end
      if (g[1]) begin
        n1++;
        if (n1 < 4) begin
          bus.req_addr[7:4] = 4'(8 + n1);
          bus.req_wdata[15:8] = 8'(8'h20 + n1);
        end else bus.req_valid[1] = 1'b0;
      end
    end
    chk("t3_n0", n0, 32'd4);
    chk("t3_n1", n1, 32'd4);
    repeat (3) step();

    // 4: same address, write by req0 and read by req1 together
    bus.req_valid = 2'b11;
    bus.req_rw = 2'b01;
    bus.req_addr = {4'd15, 4'd15};
    bus.req_wdata = {8'h00, 8'h3C};
    @(negedge clk);
    chk("t4_first", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.req_ready[1]) break;
      step();
    end
    chk("t4_grant1", 32'(bus.req_ready), 32'd2);
    step();
    bus.req_valid = 2'b00;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.rsp_valid == 2'b10) break;
      step();
    end
    chk("t4_rsp", 32'(bus.rsp_valid), 32'd2);
    chk("t4_rdata", 32'(bus.rsp_rdata), 32'h3C);
    repeat (2) step();

    // 5: reset during RDWAIT of a read
    bus.req_valid = 2'b01;
    bus.req_rw = 2'b00;
    bus.req_addr[3:0] = 4'd3;
    @(negedge clk);
    chk("t5_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 2'b00;
    step();
    rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("t5_mem_rw", 32'(mem_rw), 32'd0);
    chk("t5_mem_addr", 32'(mem_addr), 32'd0);
    chk("t5_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_rw = 2'b11;
    bus.req_addr = {4'd2, 4'd1};
    bus.req_wdata = {8'h22, 8'h11};
    @(negedge clk);
    chk("t5_first", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.req_ready[1]) break;
      step();
    end
    chk("t5_grant1", 32'(bus.req_ready), 32'd2);
    step();
    bus.req_valid = 2'b00;
    repeat (4) step();

    // 6: req1 pulses while busy and drops before IDLE
    bus.req_valid = 2'b01;
    bus.req_rw = 2'b01;
    bus.req_addr[3:0] = 4'd0;
    bus.req_wdata[7:0] = 8'h55;
    @(negedge clk);
    chk("t6_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 2'b10;
    bus.req_rw = 2'b00;
    bus.req_addr[7:4] = 4'd0;
    @(negedge clk);
    chk("t6_no_grant", 32'(bus.req_ready), 32'd0);
    step();
    bus.req_valid = 2'b00;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.rsp_valid[1]) cnt++;
      step();
    end
    chk("t6_no_rsp1", cnt, 32'd0);
    chk("q_empty", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
